ram_sp_param: RTL and testbench

Parametrised single-port synchronous RAM. It is the generalised successor to the fixed 16x16 RAM, with configurable data width, depth and read latency. It adds per-byte write enables, a hardware clear sequencer (automatic after reset, or on request), read-valid signalling and out-of-range address detection. It is used as the general scratch/storage macro on the cs/w_en/op_en bus.

---
 rtl/ram_sp_param_if.sv | 33 +++
 rtl/ram_sp_param.sv | 138 +++++++++++++
 tb/tb_ram_sp_param.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_sp_param_if.sv
// ram_sp_param_if: bus bundle for the ram_sp_param scratch/storage macro.
//   master drives : cs, w_en, op_en, addr_in, data_in, be_in, clr_req
//   slave drives  : data_out, rd_valid, init_busy, err_addr
// DATA_W and DEPTH must match the attached ram_sp_param instance.
interface ram_sp_param_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int BE_W   = DATA_W / 8;

  logic              cs;
  logic              w_en;
  logic              op_en;
  logic [ADDR_W-1:0] addr_in;
  logic [DATA_W-1:0] data_in;
  logic [BE_W-1:0]   be_in;
  logic              clr_req;
  logic [DATA_W-1:0] data_out;
  logic              rd_valid;
  logic              init_busy;
  logic              err_addr;

  modport master (
    output cs, w_en, op_en, addr_in, data_in, be_in, clr_req,
    input  data_out, rd_valid, init_busy, err_addr
  );

  modport slave (
    input  cs, w_en, op_en, addr_in, data_in, be_in, clr_req,
    output data_out, rd_valid, init_busy, err_addr
  );
endinterface

// File: rtl/ram_sp_param.sv
// ram_sp_param: parametrised single-port synchronous RAM.
//   clk       : rising-edge clock
//   reset_n   : asynchronous active-low reset
//   bus.cs/w_en/op_en/addr_in/data_in/be_in/clr_req : access bus (inputs)
//   bus.data_out  : registered read data, forced to 0 while op_en=0
//   bus.rd_valid  : one-cycle pulse with each new data_out
//   bus.init_busy : clear sequencer running; accesses ignored
//   bus.err_addr  : one-cycle pulse after an accepted access with addr_in >= DEPTH
// After reset (or clr_req in IDLE) the array is zeroed one word per cycle,
// taking exactly DEPTH cycles. READ_LAT selects 1 or 2 read register stages.
module ram_sp_param #(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 16,
  parameter int READ_LAT = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  ram_sp_param_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int BE_W   = DATA_W / 8;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;

  // One extra bit so the range compare works when DEPTH is a power of two.
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [0:0]        state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              busy;
  logic              acc;
  logic              in_range;
  logic              wr_acc;
  logic              rd_acc;
  logic [DATA_W-1:0] rd_word;

  logic              stage_vld;
  logic [DATA_W-1:0] stage_data;
  logic [DATA_W-1:0] data_q;
  logic              rd_valid_q;
  logic              err_q;

  assign busy     = (state == ST_CLEAR);
  assign acc      = bus.cs & ~busy;
  assign in_range = ({1'b0, bus.addr_in} < DEPTH_EXT);
  assign wr_acc   = acc & bus.w_en & in_range;
  assign rd_acc   = acc & ~bus.w_en;
  // Out-of-range reads still complete, returning zero.
  assign rd_word  = in_range ? mem[bus.addr_in] : '0;

  // Clear sequencer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (clr_cnt == LAST_ADDR) begin
            state   <= ST_IDLE;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: begin
          if (bus.clr_req) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
          end
        end
      endcase
    end
  end

  // Storage array: not reset; the clear sequencer owns it while busy.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[clr_cnt] <= '0;
    end else if (wr_acc) begin
      for (int unsigned i = 0; i < BE_W; i++) begin
        if (bus.be_in[i]) begin
          mem[bus.addr_in][8*i +: 8] <= bus.data_in[8*i +: 8];
        end
      end
    end
  end

  // Optional extra read stage ahead of the output register.
  generate
    if (READ_LAT == 2) begin : g_lat2
      logic              p1_vld;
      logic [DATA_W-1:0] p1_data;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          p1_vld  <= 1'b0;
          p1_data <= '0;
        end else begin
          p1_vld <= rd_acc;
          if (rd_acc) begin
            p1_data <= rd_word;
          end
        end
      end

      assign stage_vld  = p1_vld;
      assign stage_data = p1_data;
    end else begin : g_lat1
      assign stage_vld  = rd_acc;
      assign stage_data = rd_word;
    end
  endgenerate

  // Output register holds the last read value between reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q     <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rd_valid_q <= stage_vld;
      err_q      <= acc & ~in_range;
      if (stage_vld) begin
        data_q <= stage_data;
      end
    end
  end

  assign bus.data_out  = bus.op_en ? data_q : '0;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.init_busy = busy;
  assign bus.err_addr  = err_q;
endmodule

// File: tb/tb_ram_sp_param.sv
// Directed bench for ram_sp_param. Three instances share one stimulus bus:
//   u_dut0: DEPTH=16, READ_LAT=1   u_dut1: DEPTH=16, READ_LAT=2
//   u_dut2: DEPTH=12, READ_LAT=1 (non-power-of-two range checks)
module tb_ram_sp_param;
  logic        clk;
  logic        reset_n;
  logic        cs;
  logic        w_en;
  logic        op_en;
  logic        clr_req;
  logic [3:0]  addr_in;
  logic [15:0] data_in;
  logic [1:0]  be_in;

  int checks = 0;
  int errors = 0;

  ram_sp_param_if #(.DATA_W(16), .DEPTH(16)) if0 ();
  ram_sp_param_if #(.DATA_W(16), .DEPTH(16)) if1 ();
  ram_sp_param_if #(.DATA_W(16), .DEPTH(12)) if2 ();

  assign if0.cs = cs;  assign if0.w_en = w_en;  assign if0.op_en = op_en;
  assign if0.addr_in = addr_in;  assign if0.data_in = data_in;
  assign if0.be_in = be_in;  assign if0.clr_req = clr_req;
  assign if1.cs = cs;  assign if1.w_en = w_en;  assign if1.op_en = op_en;
  assign if1.addr_in = addr_in;  assign if1.data_in = data_in;
  assign if1.be_in = be_in;  assign if1.clr_req = clr_req;
  assign if2.cs = cs;  assign if2.w_en = w_en;  assign if2.op_en = op_en;
  assign if2.addr_in = addr_in;  assign if2.data_in = data_in;
  assign if2.be_in = be_in;  assign if2.clr_req = clr_req;

  ram_sp_param #(.DATA_W(16), .DEPTH(16), .READ_LAT(1)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .bus(if0));
  ram_sp_param #(.DATA_W(16), .DEPTH(16), .READ_LAT(2)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .bus(if1));
  ram_sp_param #(.DATA_W(16), .DEPTH(12), .READ_LAT(1)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int c0, c1, c2;
    reset_n = 1'b0; cs = 1'b0; w_en = 1'b0; op_en = 1'b1; clr_req = 1'b0;
    addr_in = '0; data_in = '0; be_in = '0;
    repeat (3) tick();
    checks++;
    if ({if0.init_busy, if0.rd_valid, if0.data_out, if0.err_addr} !== {1'b1, 1'b0, 16'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got busy=%b vld=%b data=%h err=%b expected 1 0 0000 0",
               if0.init_busy, if0.rd_valid, if0.data_out, if0.err_addr);
    end
    reset_n = 1'b1;
    c0 = 0; c1 = 0; c2 = 0;
    for (int k = 0; k < 40; k++) begin
      if (!(if0.init_busy | if1.init_busy | if2.init_busy)) break;
      c0 += int'(if0.init_busy);
      c1 += int'(if1.init_busy);
      c2 += int'(if2.init_busy);
      tick();
    end
    checks++;
    if (c0 !== 16) begin errors++; $display("FAIL busy_len_d16: got %0d expected 16", c0); end
    checks++;
    if (c1 !== 16) begin errors++; $display("FAIL busy_len_d16_lat2: got %0d expected 16", c1); end
    checks++;
    if (c2 !== 12) begin errors++; $display("FAIL busy_len_d12: got %0d expected 12", c2); end
    for (int a = 0; a < 16; a++) begin
      cs = 1'b1; w_en = 1'b0; addr_in = 4'(a);
      tick();
      checks++;
      if ({if0.rd_valid, if0.data_out} !== {1'b1, 16'h0000}) begin
        errors++;
        $display("FAIL post_reset_read[%0d]: got vld=%b data=%h expected 1 0000", a, if0.rd_valid, if0.data_out);
      end
    end
    cs = 1'b0;
    tick();
    checks++;
    if (if0.rd_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_drop: got %b expected 0", if0.rd_valid); end
  endtask

  task automatic test_write_read();
    cs = 1'b1; w_en = 1'b1; addr_in = 4'd3; data_in = 16'hA5C3; be_in = 2'b11;
    tick();
    checks++;
    if (if0.rd_valid !== 1'b0) begin errors++; $display("FAIL write_no_valid: got %b expected 0", if0.rd_valid); end
    w_en = 1'b0;
    tick();
    cs = 1'b0;
    checks++;
    if ({if0.rd_valid, if0.data_out} !== {1'b1, 16'hA5C3}) begin
      errors++; $display("FAIL read_lat1: got vld=%b data=%h expected 1 a5c3", if0.rd_valid, if0.data_out);
    end
    checks++;
    if (if1.rd_valid !== 1'b0) begin errors++; $display("FAIL lat2_early: got vld=%b expected 0", if1.rd_valid); end
    tick();
    checks++;
    if ({if1.rd_valid, if1.data_out} !== {1'b1, 16'hA5C3}) begin
      errors++; $display("FAIL read_lat2: got vld=%b data=%h expected 1 a5c3", if1.rd_valid, if1.data_out);
    end
    checks++;
    if ({if0.rd_valid, if0.data_out} !== {1'b0, 16'hA5C3}) begin
      errors++; $display("FAIL read_hold: got vld=%b data=%h expected 0 a5c3", if0.rd_valid, if0.data_out);
    end
  endtask

  task automatic test_byte_enables();
    cs = 1'b1; w_en = 1'b1; addr_in = 4'd5; data_in = 16'h1234; be_in = 2'b11;
    tick();
    data_in = 16'hABCD; be_in = 2'b01;
    tick();
    w_en = 1'b0;
    tick();
    checks++;
    if ({if0.rd_valid, if0.data_out} !== {1'b1, 16'h12CD}) begin
      errors++; $display("FAIL be_low: got vld=%b data=%h expected 1 12cd", if0.rd_valid, if0.data_out);
    end
    w_en = 1'b1; be_in = 2'b10;
    tick();
    w_en = 1'b0;
    tick();
    checks++;
    if ({if0.rd_valid, if0.data_out} !== {1'b1, 16'hABCD}) begin
      errors++; $display("FAIL be_high: got vld=%b data=%h expected 1 abcd", if0.rd_valid, if0.data_out);
    end
    w_en = 1'b1; be_in = 2'b00; data_in = 16'h0000;
    tick();
    w_en = 1'b0;
    tick();
    cs = 1'b0;
    checks++;
    if ({if0.rd_valid, if0.data_out} !== {1'b1, 16'hABCD}) begin
      errors++; $display("FAIL be_none: got vld=%b data=%h expected 1 abcd", if0.rd_valid, if0.data_out);
    end
  endtask

  task automatic test_op_en();
    cs = 1'b1; w_en = 1'b0; addr_in = 4'd3;
    tick();
    cs = 1'b0;
    checks++;
    if (if0.data_out !== 16'hA5C3) begin errors++; $display("FAIL op_pre: got %h expected a5c3", if0.data_out); end
    op_en = 1'b0;
    #1;
    checks++;
    if (if0.data_out !== 16'h0000) begin errors++; $display("FAIL op_gate_comb: got %h expected 0000", if0.data_out); end
    tick();
    checks++;
    if ({if0.rd_valid, if0.data_out} !== {1'b0, 16'h0000}) begin
      errors++; $display("FAIL op_gate_hold: got vld=%b data=%h expected 0 0000", if0.rd_valid, if0.data_out);
    end
    op_en = 1'b1;
    #1;
    checks++;
    if ({if0.rd_valid, if0.data_out} !== {1'b0, 16'hA5C3}) begin
      errors++; $display("FAIL op_restore: got vld=%b data=%h expected 0 a5c3", if0.rd_valid, if0.data_out);
    end
  endtask

  task automatic test_back_to_back();
    cs = 1'b1; w_en = 1'b0; addr_in = 4'd3;
    tick();
    checks++;
    if (if1.rd_valid !== 1'b0) begin errors++; $display("FAIL b2b_lat2_r0: got vld=%b expected 0", if1.rd_valid); end
    addr_in = 4'd5;
    tick();
    cs = 1'b0;
    checks++;
    if ({if1.rd_valid, if1.data_out} !== {1'b1, 16'hA5C3}) begin
      errors++; $display("FAIL b2b_lat2_r1: got vld=%b data=%h expected 1 a5c3", if1.rd_valid, if1.data_out);
    end
    checks++;
    if ({if0.rd_valid, if0.data_out} !== {1'b1, 16'hABCD}) begin
      errors++; $display("FAIL b2b_lat1_r1: got vld=%b data=%h expected 1 abcd", if0.rd_valid, if0.data_out);
    end
    tick();
    checks++;
    if ({if1.rd_valid, if1.data_out} !== {1'b1, 16'hABCD}) begin
      errors++; $display("FAIL b2b_lat2_r2: got vld=%b data=%h expected 1 abcd", if1.rd_valid, if1.data_out);
    end
    tick();
    checks++;
    if ({if1.rd_valid, if1.data_out} !== {1'b0, 16'hABCD}) begin
      errors++; $display("FAIL b2b_lat2_end: got vld=%b data=%h expected 0 abcd", if1.rd_valid, if1.data_out);
    end
  endtask

  task automatic test_clear_busy();
    int cnt;
    for (int a = 0; a < 16; a++) begin
      cs = 1'b1; w_en = 1'b1; be_in = 2'b11; data_in = 16'hFFFF; addr_in = 4'(a);
      tick();
    end
    // read in flight on the same cycle clr_req is accepted
    cs = 1'b1; w_en = 1'b0; addr_in = 4'd7; clr_req = 1'b1;
    tick();
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (!if0.init_busy) break;
      cnt++;
      cs = 1'b0; clr_req = 1'b0;
      if (k == 0) begin
        checks++;
        if ({if0.rd_valid, if0.data_out} !== {1'b1, 16'hFFFF}) begin
          errors++; $display("FAIL clr_inflight_lat1: got vld=%b data=%h expected 1 ffff", if0.rd_valid, if0.data_out);
        end
        cs = 1'b1; w_en = 1'b1; addr_in = 4'd2; data_in = 16'h1234;
      end
      if (k == 1) begin
        checks++;
        if ({if1.rd_valid, if1.data_out} !== {1'b1, 16'hFFFF}) begin
          errors++; $display("FAIL clr_inflight_lat2: got vld=%b data=%h expected 1 ffff", if1.rd_valid, if1.data_out);
        end
        checks++;
        if ({if0.err_addr, if0.rd_valid, if2.err_addr, if2.rd_valid} !== 4'b0000) begin
          errors++; $display("FAIL busy_ignore: got err/vld=%b%b%b%b expected 0000",
                             if0.err_addr, if0.rd_valid, if2.err_addr, if2.rd_valid);
        end
      end
      if (k == 3) clr_req = 1'b1;
      tick();
    end
    clr_req = 1'b0;
    checks++;
    if (cnt !== 16) begin errors++; $display("FAIL clr_len: got %0d expected 16", cnt); end
    for (int a = 0; a < 16; a++) begin
      cs = 1'b1; w_en = 1'b0; addr_in = 4'(a);
      tick();
      checks++;
      if ({if0.rd_valid, if0.data_out} !== {1'b1, 16'h0000}) begin
        errors++; $display("FAIL clr_read[%0d]: got vld=%b data=%h expected 1 0000", a, if0.rd_valid, if0.data_out);
      end
    end
    cs = 1'b0;
  endtask

  task automatic test_range_reset();
    int cnt;
    cs = 1'b1; w_en = 1'b1; addr_in = 4'd11; data_in = 16'h7777; be_in = 2'b11;
    tick();
    checks++;
    if (if2.err_addr !== 1'b0) begin errors++; $display("FAIL edge_addr_err: got %b expected 0", if2.err_addr); end
    w_en = 1'b0;
    tick();
    checks++;
    if ({if2.rd_valid, if2.data_out, if2.err_addr} !== {1'b1, 16'h7777, 1'b0}) begin
      errors++; $display("FAIL edge_addr_read: got vld=%b data=%h err=%b expected 1 7777 0",
                         if2.rd_valid, if2.data_out, if2.err_addr);
    end
    w_en = 1'b1; addr_in = 4'd13; data_in = 16'h5555;
    tick();
    checks++;
    if ({if2.err_addr, if2.rd_valid} !== 2'b10) begin
      errors++; $display("FAIL oor_write: got err=%b vld=%b expected 1 0", if2.err_addr, if2.rd_valid);
    end
    checks++;
    if (if0.err_addr !== 1'b0) begin errors++; $display("FAIL pow2_no_err: got %b expected 0", if0.err_addr); end
    w_en = 1'b0;
    tick();
    cs = 1'b0;
    checks++;
    if ({if2.err_addr, if2.rd_valid, if2.data_out} !== {1'b1, 1'b1, 16'h0000}) begin
      errors++; $display("FAIL oor_read: got err=%b vld=%b data=%h expected 1 1 0000",
                         if2.err_addr, if2.rd_valid, if2.data_out);
    end
    tick();
    checks++;
    if (if2.err_addr !== 1'b0) begin errors++; $display("FAIL err_pulse: got %b expected 0", if2.err_addr); end
    // start a clear with a read riding along, then reset mid-sequence
    cs = 1'b1; w_en = 1'b0; addr_in = 4'd11; clr_req = 1'b1;
    tick();
    cs = 1'b0; clr_req = 1'b0;
    checks++;
    if ({if2.rd_valid, if2.data_out, if2.init_busy} !== {1'b1, 16'h7777, 1'b1}) begin
      errors++; $display("FAIL pre_reset_d12: got vld=%b data=%h busy=%b expected 1 7777 1",
                         if2.rd_valid, if2.data_out, if2.init_busy);
    end
    tick();
    checks++;
    if ({if1.rd_valid, if1.data_out} !== {1'b1, 16'h7777}) begin
      errors++; $display("FAIL pre_reset_lat2: got vld=%b data=%h expected 1 7777", if1.rd_valid, if1.data_out);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({if1.rd_valid, if1.data_out, if2.data_out, if2.init_busy} !== {1'b0, 16'h0, 16'h0, 1'b1}) begin
      errors++; $display("FAIL async_reset: got vld=%b d1=%h d2=%h busy=%b expected 0 0000 0000 1",
                         if1.rd_valid, if1.data_out, if2.data_out, if2.init_busy);
    end
    tick();
    tick();
    reset_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (!if2.init_busy) break;
      cnt++;
      tick();
    end
    checks++;
    if (cnt !== 12) begin errors++; $display("FAIL reclear_len: got %0d expected 12", cnt); end
    cs = 1'b1; w_en = 1'b0; addr_in = 4'd11;
    tick();
    cs = 1'b0;
    checks++;
    if ({if2.rd_valid, if2.data_out} !== {1'b1, 16'h0000}) begin
      errors++; $display("FAIL reclear_read: got vld=%b data=%h expected 1 0000", if2.rd_valid, if2.data_out);
    end
    repeat (2) tick();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_enables();
    test_op_en();
    test_back_to_back();
    test_clear_busy();
    test_range_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
